multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath; drives the datapath side of the ALU interface.
- Issues the 4-bit ALU operation code and mux/strobe controls each cycle.
- Consumes the ALU zero flag to resolve branches.
- Sits between the instruction register (opcode/funct) and the datapath (PC, memory, register file, ALU).

Parameters:
- ALU_W, 4, width of alu_control; must be 4 for the current ALU encoding.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  IR[31:26]; stable from DECODE until instruction end.
- funct  input  6  IR[5:0]; stable from DECODE until instruction end.
- zero  input  1  ALU zero flag (alu_out == 0).
- alu_control  output  4  ALU op: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 10 NOR.
- alu_src_a  output  1  0 = PC, 1 = register A.
- alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- pc_source  output  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
- pc_write  output  1  PC load enable.
- iord  output  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  IR load enable.
- reg_dst  output  1  0 = rt, 1 = rd.
- mem_to_reg  output  1  0 = ALUOut, 1 = MDR.
- reg_write  output  1  register file write enable.
- instr_done  output  1  high in the final cycle of every instruction.
- illegal_op  output  1  one-cycle pulse in DECODE on an unsupported opcode or funct.
- state  output  4  current state encoding, for debug and bench.

Behaviour:
- One clock domain. Reset is synchronous, active-high. The state register updates on the rising clk edge only.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12–15 are unreachable and recover to FETCH on the next edge.
- Reset:
  - While reset is high, all strobes are 0 (pc_write, mem_read, mem_write, ir_write, reg_write, instr_done, illegal_op).
  - While reset is high, alu_control = 2 and all mux selects = 0.
  - After the edge with reset high, state = FETCH. This applies mid-instruction too: no write strobe is issued in the reset cycle, and the partial instruction is abandoned.
- Outputs are decoded from state (Moore), except pc_write in BRANCH, which is Mealy on zero. Unlisted outputs are 0. alu_control = 2 unless stated.
- Per-state outputs:
  - FETCH: mem_read=1, ir_write=1, alu_src_b=01, pc_write=1. Next: DECODE.
  - DECODE: alu_src_b=11 (branch target precompute). Next by opcode:
    - 100011 or 101011 → MEMADR.
    - 000000 with legal funct → EXEC.
    - 000100 → BRANCH.
    - 001000 → ADDIEX.
    - 000010 → JUMP.
    - Otherwise → FETCH, with illegal_op=1 and instr_done=1.
  - MEMADR: alu_src_a=1, alu_src_b=10. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD: iord=1, mem_read=1. Next: MEMWB.
  - MEMWB: mem_to_reg=1, reg_write=1, instr_done=1. Next: FETCH.
  - MEMWR: iord=1, mem_write=1, instr_done=1. Next: FETCH.
  - EXEC: alu_src_a=1, alu_src_b=00. alu_control by funct: 100000→2, 100010→6, 100100→0, 100101→1, 101010→7, 100111→10. Next: ALUWB.
  - ALUWB: reg_dst=1, reg_write=1, instr_done=1. Next: FETCH.
  - BRANCH: alu_src_a=1, alu_control=6, pc_source=01, pc_write=zero, instr_done=1. Next: FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10. Next: ADDIWB.
  - ADDIWB: reg_write=1, instr_done=1. Next: FETCH.
  - JUMP: pc_source=10, pc_write=1, instr_done=1. Next: FETCH.
- Latency in cycles including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Invariants:
  - mem_read and mem_write are never high together.
  - reg_write and pc_write are never high together.
  - zero is sampled only in BRANCH.

Optional Feature:
- Macro: MULTICYCLE_CTRL_BNE_EN.
- Defined: opcode 000101 (bne) is legal; DECODE → BRANCH. In BRANCH, pc_write = ~zero for bne and zero for beq. The branch sense is latched in a 1-bit register at DECODE.
- Undefined: 000101 is illegal (illegal_op pulse, return to FETCH), and the sense register is absent.

Test Plan:
- Reset held 2 cycles, then released with opcode=100011 → state sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in cycle 5. instr_done high in MEMWB.
- R-type, funct=100111 → EXEC drives alu_control=10, alu_src_a=1, alu_src_b=00. ALUWB has reg_dst=1, reg_write=1.
- beq with zero=1 → pc_write=1 with pc_source=01 in BRANCH. Repeat with zero=0 → pc_write=0. Both return to FETCH after 3 cycles.
- Illegal inputs: opcode=111111, and opcode=000000 with funct=000000 → illegal_op pulses in DECODE, next state FETCH, no reg_write or mem_write ever asserted.
- Reset asserted during MEMRD of lw → next state FETCH, no MEMWB cycle, all strobes 0 during the reset cycle.
- MULTICYCLE_CTRL_BNE_EN defined, opcode=000101, zero=0 → pc_write=1 in BRANCH. Undefined build → illegal_op=1.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multicycle MIPS datapath (optional bne via MULTICYCLE_CTRL_BNE_EN)
module multicycle_control #(
  parameter int ALU_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic [ALU_W-1:0] alu_control,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic             pc_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(6);
  localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(7);
  localparam logic [ALU_W-1:0] ALU_NOR = ALU_W'(10);

  state_t           cur;
  state_t           decode_next;
  logic             op_ok;
  logic             funct_ok;
  logic [ALU_W-1:0] funct_alu;
  logic             branch_take;

  assign state = cur;

  // R-type funct decode: ALU op and legality
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      6'b100111: funct_alu = ALU_NOR;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // opcode dispatch out of DECODE; unsupported encodings fall back to FETCH
  always_comb begin
    decode_next = S_FETCH;
    op_ok       = 1'b1;
    case (opcode)
      OP_LW, OP_SW: decode_next = S_MEMADR;
      OP_RTYPE: begin
        if (funct_ok) decode_next = S_EXEC;
        else          op_ok       = 1'b0;
      end
      OP_BEQ:  decode_next = S_BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
      OP_BNE:  decode_next = S_BRANCH;
`endif
      OP_ADDI: decode_next = S_ADDIEX;
      OP_J:    decode_next = S_JUMP;
      default: op_ok       = 1'b0;
    endcase
  end

`ifdef MULTICYCLE_CTRL_BNE_EN
  logic bne_q;

  // branch sense captured at DECODE so BRANCH does not depend on opcode timing
  always_ff @(posedge clk) begin
    if (reset)                 bne_q <= 1'b0;
    else if (cur == S_DECODE)  bne_q <= (opcode == OP_BNE);
  end

  assign branch_take = bne_q ? ~zero : zero;
`else
  assign branch_take = zero;
`endif

  // state register; reset abandons any partial instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:  cur <= S_DECODE;
        S_DECODE: cur <= decode_next;
        S_MEMADR: cur <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  cur <= S_MEMWB;
        S_EXEC:   cur <= S_ALUWB;
        S_ADDIEX: cur <= S_ADDIWB;
        default:  cur <= S_FETCH;
      endcase
    end
  end

  // Moore output decode; pc_write in BRANCH follows zero; reset forces idle outputs
  always_comb begin
    alu_control = ALU_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_source   = 2'b00;
    pc_write    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (!reset) begin
      case (cur)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          alu_src_b = 2'b01;
          pc_write  = 1'b1;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          illegal_op = ~op_ok;
          instr_done = ~op_ok;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_EXEC: begin
          alu_src_a   = 1'b1;
          alu_control = funct_alu;
        end
        S_ALUWB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a   = 1'b1;
          alu_control = ALU_SUB;
          pc_source   = 2'b01;
          pc_write    = branch_take;
          instr_done  = 1'b1;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_source  = 2'b10;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic [3:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  int compared   = 0;
  int mismatched = 0;

  multicycle_control #(.ALU_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .pc_write(pc_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // advance one clock and sample 1 ns after the edge; invariants on every cycle
  task automatic step();
    @(posedge clk);
    #1;
    chk("inv_mem_rw", {31'd0, mem_read & mem_write}, 32'd0);
    chk("inv_reg_pc", {31'd0, reg_write & pc_write}, 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 6'b100011;
    funct  = 6'b000000;
    zero   = 1'b0;

    // reset held two cycles
    step();
    step();
    chk("rst_state", state, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_ir_write", ir_write, 0);
    chk("rst_alu_ctl", alu_control, 2);
    chk("rst_src_b", alu_src_b, 0);

    // lw: 0,1,2,3,4,0
    reset = 1'b0;
    #1;
    chk("lw_c1_state", state, 0);
    chk("lw_c1_fetch", {mem_read, ir_write, pc_write, alu_src_b}, 5'b111_01);
    chk("lw_c1_regw", reg_write, 0);
    step();
    chk("lw_c2_state", state, 1);
    chk("lw_c2_srcb", alu_src_b, 3);
    chk("lw_c2_regw", reg_write, 0);
    step();
    chk("lw_c3_state", state, 2);
    chk("lw_c3_src", {alu_src_a, alu_src_b}, 3'b1_10);
    step();
    chk("lw_c4_state", state, 3);
    chk("lw_c4_rd", {iord, mem_read, reg_write}, 3'b110);
    step();
    chk("lw_c5_state", state, 4);
    chk("lw_c5_wb", {reg_write, mem_to_reg, instr_done}, 3'b111);
    step();
    chk("lw_end_state", state, 0);

    // R-type NOR
    opcode = 6'b000000;
    funct  = 6'b100111;
    step();
    chk("r_dec_state", state, 1);
    chk("r_dec_illegal", illegal_op, 0);
    step();
    chk("r_exec_state", state, 6);
    chk("r_exec_alu", alu_control, 10);
    chk("r_exec_src", {alu_src_a, alu_src_b}, 3'b1_00);
    step();
    chk("r_wb_state", state, 7);
    chk("r_wb_ctl", {reg_dst, reg_write, instr_done}, 3'b111);
    step();
    chk("r_end_state", state, 0);

    // R-type SLT
    funct = 6'b101010;
    step();
    step();
    chk("slt_alu", alu_control, 7);

    // beq taken
    step();
    step();
    chk("beq1_fetch", state, 0);
    opcode = 6'b000100;
    zero   = 1'b1;
    step();
    step();
    chk("beq1_state", state, 8);
    chk("beq1_pcw", pc_write, 1);
    chk("beq1_pcsrc", pc_source, 1);
    chk("beq1_alu", alu_control, 6);
    chk("beq1_done", instr_done, 1);
    step();
    chk("beq1_end", state, 0);

    // beq not taken
    zero = 1'b0;
    step();
    step();
    chk("beq0_state", state, 8);
    chk("beq0_pcw", pc_write, 0);
    step();
    chk("beq0_end", state, 0);

    // illegal opcode
    opcode = 6'b111111;
    step();
    chk("ill1_state", state, 1);
    chk("ill1_flags", {illegal_op, instr_done, reg_write, mem_write}, 4'b1100);
    step();
    chk("ill1_end", state, 0);
    chk("ill1_nopulse", illegal_op, 0);

    // illegal funct
    opcode = 6'b000000;
    funct  = 6'b000000;
    step();
    chk("ill2_flags", {illegal_op, instr_done, reg_write, mem_write}, 4'b1100);
    step();
    chk("ill2_end", state, 0);

    // sw
    opcode = 6'b101011;
    step();
    step();
    chk("sw_adr", state, 2);
    step();
    chk("sw_state", state, 5);
    chk("sw_wr", {iord, mem_write, mem_read, instr_done}, 4'b1101);
    step();
    chk("sw_end", state, 0);

    // addi
    opcode = 6'b001000;
    step();
    step();
    chk("addi_ex", state, 9);
    chk("addi_ex_src", {alu_src_a, alu_src_b}, 3'b1_10);
    step();
    chk("addi_wb", {state, reg_write, reg_dst, instr_done}, 7'b1010_101);
    step();
    chk("addi_end", state, 0);

    // jump
    opcode = 6'b000010;
    step();
    step();
    chk("j_state", state, 11);
    chk("j_ctl", {pc_source, pc_write, instr_done}, 4'b10_11);
    step();
    chk("j_end", state, 0);

    // reset asserted during MEMRD of lw
    opcode = 6'b100011;
    step();
    step();
    step();
    chk("rr_memrd", state, 3);
    reset = 1'b1;
    #1;
    chk("rr_strobes", {pc_write, mem_read, mem_write, ir_write, reg_write, instr_done, illegal_op}, 7'd0);
    step();
    chk("rr_state", state, 0);
    reset = 1'b0;
    step();
    chk("rr_decode", state, 1);
    step();
    step();
    step();
    step();
    chk("rr_lw_end", state, 0);

    // bne
    opcode = 6'b000101;
    zero   = 1'b0;
    step();
`ifdef MULTICYCLE_CTRL_BNE_EN
    chk("bne_dec_illegal", illegal_op, 0);
    step();
    chk("bne_state", state, 8);
    chk("bne_pcw", pc_write, 1);
    zero = 1'b1;
    #1;
    chk("bne_pcw_z1", pc_write, 0);
    step();
    chk("bne_end", state, 0);
`else
    chk("bne_illegal", illegal_op, 1);
    step();
    chk("bne_end", state, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
